alarm_mode: RTL and testbench
=============================

// Module: alarm_mode
// PURPOSE
//  Alarm-time store and comparator. It is the producing end of the clock block's in_alarm input.
//  - User sets an alarm HH:MM through a set/op1/op2 button FSM.
//  - The block watches realTime from the clock block.
//  - When realTime reaches the stored alarm time and the alarm is armed, it emits a 1-cycle
//    alarm_fire pulse, which drives the clock block's in_alarm.
//  - It also supplies display digits and flicker mask to the mode mux.
// PARAMETERS
//  SNOOZE_MIN  5  minutes added to alarm time on snooze; legal 1..59
//  DEFAULT_HH  0  alarm hour after reset (0..23)
//  DEFAULT_MM  0  alarm minute after reset (0..59)
// PORTS
//  clk_2MHz     in   1   system clock
//  reset        in   1   asynchronous, active-high
//  ASSERT       in   1   button-event qualifier; buttons are sampled only when ASSERT=1
//  in_set       in   1   set button (level, qualified by ASSERT)
//  in_op1       in   1   op1 button: inc / arm toggle
//  in_op2       in   1   op2 button: dec / snooze
//  realTime     in   21  current time {HH[20:14],MM[13:7],SS[6:0]}, binary
//  out_state    out  2   0=VIEW, 1=SET_HH, 2=SET_MM
//  out_armed    out  1   alarm enabled
//  outHH        out  7   displayed hour
//  outMM        out  7   displayed minute
//  outSS        out  7   displayed second; always 0
//  out_flick    out  6   digit flicker mask {HH1,HH0,MM1,MM0,SS1,SS0}
//  alarm_fire   out  1   1-cycle pulse to the clock block's in_alarm
// BEHAVIOUR
//  Reset (async, any state):
//   - state=VIEW; alarm reg = DEFAULT_HH:DEFAULT_MM; working copy = alarm reg; armed=0; alarm_fire=0.
//   - match_d=1, so no fire occurs on the first cycle after reset.
//   - Reset in SET_HH/SET_MM discards the working copy.
//  Button event: ASSERT=1 at a clk edge. All buttons are ignored when ASSERT=0.
//  Priority within one event: in_set > in_op1 > in_op2. Lower-priority buttons in the same cycle are ignored.
//  FSM (all registered, 1-cycle latency):
//   VIEW, set:     working copy <= alarm reg; go to SET_HH.
//   VIEW, op1:     armed <= ~armed.
//   VIEW, op2:     if armed, snooze: alarm MM += SNOOZE_MIN.
//                  - MM>=60: MM-=60, HH=(HH+1)%24.
//                  - If disarmed, op2 has no effect.
//   SET_HH, op1/op2: wHH +1 / -1 mod 24 (23+1->0, 0-1->23); set -> SET_MM.
//   SET_MM, op1/op2: wMM +1 / -1 mod 60 (59+1->0, 0-1->59). No carry into HH.
//   SET_MM, set:   commit working copy to alarm reg; armed<=1; go to VIEW.
//   state code 3:  illegal; go to VIEW next cycle.
//  Display:
//   - VIEW shows alarm reg; SET_* shows working copy; outSS=0.
//   - out_flick: VIEW=000000, SET_HH=110000, SET_MM=001100.
//  Compare (every cycle, in every state):
//   - match = (realTime == {almHH, almMM, 7'd0}), using alarm reg values at the start of the cycle.
//   - match_d <= match.
//   - alarm_fire <= armed & match & ~match_d. One pulse per reaching of HH:MM:00, registered.
//  Boundary cases:
//   - Commit or snooze that lands on the current realTime in the same cycle:
//     match is evaluated on the next cycle, so it fires once.
//   - Arming while realTime already equals the alarm time: no fire (match_d already 1).
//   - Editing in SET_* does not disturb a pending match; the compare uses the committed reg.
//   - realTime held constant: exactly one pulse.
//   - Time set backward then forward past the alarm: fires again on each new match edge.
// TESTING
//  T1 reset; set, op1 x7, set, op1 x30, set -> alarm 07:30, armed=1, state=0, outHH=7, outMM=30.
//  T2 drive realTime 07:29:59 then 07:30:00, held 100 cycles -> alarm_fire high exactly 1 cycle, 1 clk after match.
//  T3 alarm 23:58, op2 in VIEW with SNOOZE_MIN=5 -> alarm 00:03; disarmed op2 -> unchanged.
//  T4 SET_HH op2 at 0 -> 23; SET_MM op1 at 59 -> 0, HH unchanged; in_set+in_op1 same event -> only state advances.
//  T5 ASSERT=0 with buttons toggling -> no state or value change; reset asserted in SET_MM -> VIEW, 00:00, armed=0.
//  T6 op1 toggles armed=0 at match cycle -> no alarm_fire; re-arm while match held -> still no fire.

Source files
------------

// File: rtl/alarm_mode.sv
// Alarm-time store and comparator. Holds an HH:MM alarm edited through a
// set/op1/op2 button FSM, watches realTime, and emits a one-cycle
// alarm_fire pulse on each rising edge of the alarm match.
module alarm_mode #(
   parameter int SNOOZE_MIN = 5,
   parameter int DEFAULT_HH = 0,
   parameter int DEFAULT_MM = 0
) (
   input  logic        clk_2MHz,
   input  logic        reset,
   input  logic        ASSERT,
   input  logic        in_set,
   input  logic        in_op1,
   input  logic        in_op2,
   input  logic [20:0] realTime,
   output logic [1:0]  out_state,
   output logic        out_armed,
   output logic [6:0]  outHH,
   output logic [6:0]  outMM,
   output logic [6:0]  outSS,
   output logic [5:0]  out_flick,
   output logic        alarm_fire
);

   typedef enum logic [1:0] {
      ST_VIEW   = 2'd0,
      ST_SET_HH = 2'd1,
      ST_SET_MM = 2'd2,
      ST_BAD    = 2'd3
   } state_t;

   localparam logic [6:0] DEF_HH = 7'(DEFAULT_HH);
   localparam logic [6:0] DEF_MM = 7'(DEFAULT_MM);
   localparam logic [6:0] SNZ    = 7'(SNOOZE_MIN);

   state_t     state_q, state_d;
   logic [6:0] alm_hh_q, alm_hh_d, alm_mm_q, alm_mm_d;
   logic [6:0] w_hh_q, w_hh_d, w_mm_q, w_mm_d;
   logic       armed_q, armed_d;
   logic       match_d_q, match;
   logic       fire_q, fire_d;
   logic [6:0] disp_hh_q, disp_hh_d, disp_mm_q, disp_mm_d;
   logic [5:0] flick_q, flick_d;
   logic       ev_set, ev_op1, ev_op2;
   logic [6:0] snz_mm;

   // Button decode, FSM next state, display selection and alarm compare.
   always_comb begin
      // One event per cycle: set beats op1 beats op2.
      ev_set = ASSERT & in_set;
      ev_op1 = ASSERT & in_op1 & ~in_set;
      ev_op2 = ASSERT & in_op2 & ~in_set & ~in_op1;
      // Max 59+59 = 118, fits in 7 bits.
      snz_mm = alm_mm_q + SNZ;

      state_d  = state_q;
      alm_hh_d = alm_hh_q;
      alm_mm_d = alm_mm_q;
      w_hh_d   = w_hh_q;
      w_mm_d   = w_mm_q;
      armed_d  = armed_q;

      case (state_q)
         ST_VIEW: begin
            if (ev_set) begin
               w_hh_d  = alm_hh_q;
               w_mm_d  = alm_mm_q;
               state_d = ST_SET_HH;
            end else if (ev_op1) begin
               armed_d = ~armed_q;
            end else if (ev_op2 && armed_q) begin
               if (snz_mm >= 7'd60) begin
                  alm_mm_d = snz_mm - 7'd60;
                  alm_hh_d = (alm_hh_q == 7'd23) ? 7'd0 : alm_hh_q + 7'd1;
               end else begin
                  alm_mm_d = snz_mm;
               end
            end
         end
         ST_SET_HH: begin
            if (ev_set)      state_d = ST_SET_MM;
            else if (ev_op1) w_hh_d = (w_hh_q == 7'd23) ? 7'd0 : w_hh_q + 7'd1;
            else if (ev_op2) w_hh_d = (w_hh_q == 7'd0) ? 7'd23 : w_hh_q - 7'd1;
         end
         ST_SET_MM: begin
            if (ev_set) begin
               alm_hh_d = w_hh_q;
               alm_mm_d = w_mm_q;
               armed_d  = 1'b1;
               state_d  = ST_VIEW;
            end else if (ev_op1) begin
               w_mm_d = (w_mm_q == 7'd59) ? 7'd0 : w_mm_q + 7'd1;
            end else if (ev_op2) begin
               w_mm_d = (w_mm_q == 7'd0) ? 7'd59 : w_mm_q - 7'd1;
            end
         end
         default: state_d = ST_VIEW;
      endcase

      // Display follows the next state so it lines up with out_state.
      disp_hh_d = alm_hh_d;
      disp_mm_d = alm_mm_d;
      flick_d   = 6'b000000;
      case (state_d)
         ST_SET_HH: begin
            disp_hh_d = w_hh_d;
            disp_mm_d = w_mm_d;
            flick_d   = 6'b110000;
         end
         ST_SET_MM: begin
            disp_hh_d = w_hh_d;
            disp_mm_d = w_mm_d;
            flick_d   = 6'b001100;
         end
         default: ;
      endcase

      // Compare against the committed alarm only; edits never disturb it.
      match  = (realTime == {alm_hh_q, alm_mm_q, 7'd0});
      fire_d = armed_q & match & ~match_d_q;
   end

   // State and output registers; match history starts at 1 to block a fire right after reset.
   always_ff @(posedge clk_2MHz or posedge reset) begin
      if (reset) begin
         state_q   <= ST_VIEW;
         alm_hh_q  <= DEF_HH;
         alm_mm_q  <= DEF_MM;
         w_hh_q    <= DEF_HH;
         w_mm_q    <= DEF_MM;
         armed_q   <= 1'b0;
         match_d_q <= 1'b1;
         fire_q    <= 1'b0;
         disp_hh_q <= DEF_HH;
         disp_mm_q <= DEF_MM;
         flick_q   <= 6'b000000;
      end else begin
         state_q   <= state_d;
         alm_hh_q  <= alm_hh_d;
         alm_mm_q  <= alm_mm_d;
         w_hh_q    <= w_hh_d;
         w_mm_q    <= w_mm_d;
         armed_q   <= armed_d;
         match_d_q <= match;
         fire_q    <= fire_d;
         disp_hh_q <= disp_hh_d;
         disp_mm_q <= disp_mm_d;
         flick_q   <= flick_d;
      end
   end

   assign out_state  = state_q;
   assign out_armed  = armed_q;
   assign outHH      = disp_hh_q;
   assign outMM      = disp_mm_q;
   assign outSS      = 7'd0;
   assign out_flick  = flick_q;
   assign alarm_fire = fire_q;

endmodule

// File: tb/tb_alarm_mode.sv
// Bench for alarm_mode: directed scenarios plus random button/time traffic,
// checked every cycle against a minutes-of-day behavioural model.
module tb_alarm_mode;

   localparam int SNOOZE = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ASSERT = 1'b0, in_set = 1'b0, in_op1 = 1'b0, in_op2 = 1'b0;
   logic [20:0] realTime = '0;
   logic [1:0]  out_state;
   logic        out_armed, alarm_fire;
   logic [6:0]  outHH, outMM, outSS;
   logic [5:0]  out_flick;

   int n_chk = 0, n_fail = 0;

   alarm_mode #(.SNOOZE_MIN(SNOOZE), .DEFAULT_HH(0), .DEFAULT_MM(0)) dut (
      .clk_2MHz(clk), .reset(reset), .ASSERT(ASSERT), .in_set(in_set),
      .in_op1(in_op1), .in_op2(in_op2), .realTime(realTime),
      .out_state(out_state), .out_armed(out_armed), .outHH(outHH),
      .outMM(outMM), .outSS(outSS), .out_flick(out_flick),
      .alarm_fire(alarm_fire));

   always #5 clk = ~clk;

   function automatic logic [20:0] tm(input int h, input int m, input int s);
      return {7'(h), 7'(m), 7'(s)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: alarm kept as minutes-of-day, working copy as separate HH/MM.
   int m_state, m_alm, m_whh, m_wmm;
   bit m_armed, m_prev, m_fire, m_match, es, e1, e2;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_state = 0; m_alm = 0; m_whh = 0; m_wmm = 0;
         m_armed = 0; m_prev = 1; m_fire = 0;
      end else begin
         m_match = (realTime == tm(m_alm / 60, m_alm % 60, 0));
         m_fire  = m_armed && m_match && !m_prev;
         m_prev  = m_match;
         es = ASSERT && in_set;
         e1 = ASSERT && in_op1 && !in_set;
         e2 = ASSERT && in_op2 && !in_set && !in_op1;
         case (m_state)
            0: if (es) begin m_whh = m_alm / 60; m_wmm = m_alm % 60; m_state = 1; end
               else if (e1) m_armed = !m_armed;
               else if (e2 && m_armed) m_alm = (m_alm + SNOOZE) % 1440;
            1: if (es) m_state = 2;
               else if (e1) m_whh = (m_whh + 1) % 24;
               else if (e2) m_whh = (m_whh + 23) % 24;
            default: if (es) begin m_alm = m_whh * 60 + m_wmm; m_armed = 1; m_state = 0; end
               else if (e1) m_wmm = (m_wmm + 1) % 60;
               else if (e2) m_wmm = (m_wmm + 59) % 60;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!reset) begin
         chk("state", int'(out_state), m_state);
         chk("armed", int'(out_armed), int'(m_armed));
         chk("hh", int'(outHH), (m_state == 0) ? m_alm / 60 : m_whh);
         chk("mm", int'(outMM), (m_state == 0) ? m_alm % 60 : m_wmm);
         chk("ss", int'(outSS), 0);
         chk("flick", int'(out_flick), (m_state == 1) ? 6'b110000 : (m_state == 2) ? 6'b001100 : 0);
         chk("fire", int'(alarm_fire), int'(m_fire));
      end
   end

   // One button event spanning exactly one rising edge; starts and ends on a falling edge.
   task automatic ev(input bit s, input bit o1, input bit o2);
      ASSERT = 1; in_set = s; in_op1 = o1; in_op2 = o2;
      @(negedge clk);
      ASSERT = 0; in_set = 0; in_op1 = 0; in_op2 = 0;
   endtask

   task automatic rep(input bit s, input bit o1, input bit o2, input int n);
      for (int i = 0; i < n; i++) ev(s, o1, o2);
   endtask

   task automatic count_fire(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (alarm_fire) cnt++;
      end
   endtask

   int cnt;

   initial begin
      realTime = tm(12, 0, 0);
      @(negedge clk); @(negedge clk);
      // T1: reset state, then program 07:30.
      chk("rst_state", int'(out_state), 0);
      chk("rst_armed", int'(out_armed), 0);
      chk("rst_fire", int'(alarm_fire), 0);
      reset = 0;
      @(negedge clk);
      ev(1, 0, 0); rep(0, 1, 0, 7); ev(1, 0, 0); rep(0, 1, 0, 30); ev(1, 0, 0);
      chk("t1_state", int'(out_state), 0);
      chk("t1_armed", int'(out_armed), 1);
      chk("t1_hh", int'(outHH), 7);
      chk("t1_mm", int'(outMM), 30);
      chk("t1_model_alm", m_alm, 450);

      // T2: reach 07:30:00 and hold -> single pulse one clock after match.
      realTime = tm(7, 29, 59);
      repeat (3) @(negedge clk);
      realTime = tm(7, 30, 0);
      @(negedge clk);
      chk("t2_fire_first", int'(alarm_fire), 1);
      count_fire(100, cnt);
      chk("t2_fire_extra", cnt, 0);

      // T3: program 23:58, snooze wraps to 00:03; disarmed snooze is inert.
      ev(1, 0, 0); rep(0, 0, 1, 8); ev(1, 0, 0); rep(0, 1, 0, 28); ev(1, 0, 0);
      chk("t3_hh", int'(outHH), 23);
      chk("t3_mm", int'(outMM), 58);
      ev(0, 0, 1);
      chk("t3_snz_hh", int'(outHH), 0);
      chk("t3_snz_mm", int'(outMM), 3);
      ev(0, 1, 0); ev(0, 0, 1);
      chk("t3_dis_armed", int'(out_armed), 0);
      chk("t3_dis_mm", int'(outMM), 3);

      // T4: hour wrap down, set beats op1, minute wrap up without carry.
      ev(1, 0, 0); ev(0, 0, 1);
      chk("t4_hh_wrap", int'(outHH), 23);
      ev(1, 1, 0);
      chk("t4_prio_state", int'(out_state), 2);
      chk("t4_prio_hh", int'(outHH), 23);
      rep(0, 1, 0, 56);
      chk("t4_mm59", int'(outMM), 59);
      ev(0, 1, 0);
      chk("t4_mm_wrap", int'(outMM), 0);
      chk("t4_hh_keep", int'(outHH), 23);

      // T5: buttons without ASSERT do nothing; async reset in SET_MM.
      for (int i = 0; i < 10; i++) begin
         in_set = 1'($urandom); in_op1 = 1'($urandom); in_op2 = 1'($urandom);
         @(negedge clk);
      end
      in_set = 0; in_op1 = 0; in_op2 = 0;
      chk("t5_noassert_state", int'(out_state), 2);
      chk("t5_noassert_mm", int'(outMM), 0);
      #2 reset = 1;
      #1;
      chk("t5_rst_state", int'(out_state), 0);
      chk("t5_rst_hh", int'(outHH), 0);
      chk("t5_rst_mm", int'(outMM), 0);
      chk("t5_rst_armed", int'(out_armed), 0);
      @(negedge clk); reset = 0; @(negedge clk);

      // T6: disarm before match -> no fire; re-arm during held match -> no fire;
      // step back and forward -> fires again.
      realTime = tm(5, 0, 0);
      ev(0, 1, 0); ev(0, 1, 0);
      realTime = tm(0, 0, 0);
      count_fire(5, cnt);
      chk("t6_disarmed", cnt, 0);
      ev(0, 1, 0);
      count_fire(10, cnt);
      chk("t6_rearm_held", cnt, 0);
      realTime = tm(0, 0, 1);
      @(negedge clk);
      realTime = tm(0, 0, 0);
      count_fire(10, cnt);
      chk("t6_refire", cnt, 1);

      // Random traffic: buttons, ASSERT gating, times near the alarm, occasional reset.
      for (int i = 0; i < 4000; i++) begin
         ASSERT = ($urandom_range(0, 1) == 1);
         in_set = ($urandom_range(0, 9) == 0);
         in_op1 = ($urandom_range(0, 3) == 0);
         in_op2 = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 5))
            0: realTime = tm(m_alm / 60, m_alm % 60, 0);
            1: realTime = tm($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 1));
            default: ;
         endcase
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1;
            @(negedge clk);
            reset = 0;
         end else begin
            @(negedge clk);
         end
      end
      ASSERT = 0; in_set = 0; in_op1 = 0; in_op2 = 0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
